// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//
// Stall/flush controller for a classic 5-stage pipeline (IF, ID, EX, MEM, WB).
//
// Responsibilities:
//   * Sequences variable-latency data-memory accesses from the MEM stage over
//     a req/ack handshake. A bounded wait raises a sticky timeout error.
//   * Freezes the front of the pipeline while memory is outstanding and
//     injects a bubble into MEM/WB.
//   * Redirects fetch and squashes the three younger stages on a branch that
//     resolves taken in MEM.
//   * Detects load-use hazards at ID. It holds PC and IF/ID for one cycle
//     and sends a bubble into ID/EX.
//   * Keeps a saturating count of stalled cycles.
//
// Parameters:
//   TIMEOUT      WAIT cycles tolerated without ack before error (1..2**CNT_W)
//   CNT_W        width of the internal wait counter
//
// Ports:
//   CLK          clock, rising edge
//   RST          asynchronous, active-high reset
//   MEM_MemRead  load in MEM stage
//   MEM_MemWrite store in MEM stage
//   MEM_Branch   branch in MEM stage
//   MEM_zero     ALU zero flag for that branch
//   EX_MemRead   instruction in EX is a load
//   EX_WriteReg  destination register of the EX instruction
//   ID_Rs/ID_Rt  source registers of the ID instruction
//   dmem_ack     data memory completes the access this cycle
//   dmem_req     data memory access request (combinational)
//   PCWrite      PC load enable
//   PCSrc        select branch target for the next PC
//   IFID_Write, IDEX_Write, EXMEM_Write   pipeline register load enables
//   IFID_Flush, IDEX_Flush, EXMEM_Flush   load a NOP/bubble instead
//   MEMWB_Bubble load a bubble (RegWrite=0) into MEM/WB
//   mem_err      sticky timeout error, cleared only by RST
//   stall_cycles saturating count of stalled cycles
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic        MEM_Branch,
    input  logic        MEM_zero,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_WriteReg,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic        dmem_ack,
    output logic        dmem_req,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic        IFID_Write,
    output logic        IDEX_Write,
    output logic        EXMEM_Write,
    output logic        IFID_Flush,
    output logic        IDEX_Flush,
    output logic        EXMEM_Flush,
    output logic        MEMWB_Bubble,
    output logic        mem_err,
    output logic [15:0] stall_cycles
);

    // Value of wait_cnt in the last WAIT cycle that may still be rescued by an
    // ack. With TIMEOUT == 2**CNT_W this is all-ones, so the counter never
    // wraps before the timeout decision is made.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_nxt;

    logic access;
    logic branch_taken;
    logic load_use;
    logic mstall;
    logic stall_event;

    assign access       = MEM_MemRead | MEM_MemWrite;
    assign branch_taken = MEM_Branch & MEM_zero;

    // Register $zero is never a real producer, so a load targeting it cannot
    // create a hazard.
    assign load_use = EX_MemRead
                    & (EX_WriteReg != 5'd0)
                    & ((EX_WriteReg == ID_Rs) | (EX_WriteReg == ID_Rt));

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples values from before the edge, independent of block ordering.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            IDLE: begin
                // A same-cycle ack completes the access without leaving IDLE.
                if (access && !dmem_ack) begin
                    state_nxt    = WAIT;
                    wait_cnt_nxt = '0;
                end
            end
            WAIT: begin
                // The ack is checked first, so an ack in the final WAIT cycle
                // wins over the timeout.
                if (dmem_ack) begin
                    state_nxt = IDLE;
                end else if (wait_cnt == LAST_CNT) begin
                    state_nxt = ERR;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            ERR: begin
                // Terminal: only RST leaves this state.
                state_nxt = ERR;
            end
            default: begin
                state_nxt    = IDLE;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic (combinational from state and current inputs)
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output is given a default first so that no path through
        // the priority chain can leave a signal unassigned and infer a latch.
        dmem_req     = 1'b0;
        PCWrite      = 1'b1;
        PCSrc        = 1'b0;
        IFID_Write   = 1'b1;
        IDEX_Write   = 1'b1;
        EXMEM_Write  = 1'b1;
        IFID_Flush   = 1'b0;
        IDEX_Flush   = 1'b0;
        EXMEM_Flush  = 1'b0;
        MEMWB_Bubble = 1'b0;
        stall_event  = 1'b0;

        dmem_req = ((state == IDLE) && access) || (state == WAIT);
        mstall   = (dmem_req && !dmem_ack) || (state == ERR);

        if (mstall) begin
            // Memory outstanding (or dead): freeze everything upstream of
            // MEM/WB. Do not let WB retire a half-finished MEM instruction.
            PCWrite      = 1'b0;
            IFID_Write   = 1'b0;
            IDEX_Write   = 1'b0;
            EXMEM_Write  = 1'b0;
            MEMWB_Bubble = 1'b1;
            stall_event  = 1'b1;
        end else if (branch_taken) begin
            // Redirect fetch and squash IF, ID and EX. A load-use hazard at the
            // same time is moot because the load in EX is squashed here too.
            PCSrc       = 1'b1;
            IFID_Flush  = 1'b1;
            IDEX_Flush  = 1'b1;
            EXMEM_Flush = 1'b1;
        end else if (load_use) begin
            // Hold PC and IF/ID for one cycle. Send a bubble into EX so the
            // load moves on to MEM and its data can be forwarded next cycle.
            PCWrite     = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Flush  = 1'b1;
            stall_event = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Sticky error flag: set on entry to ERR and held until reset
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mem_err <= 1'b0;
        end else if (state_nxt == ERR) begin
            mem_err <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Saturating stall-cycle counter
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cycles <= 16'd0;
        end else if (stall_event && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
//
// Self-checking bench for pipeline_ctrl. The combinational control rules come
// from a vector table applied while the FSM stays in IDLE. Hand-written
// sequences cover the multi-cycle memory cases: multi-cycle store,
// back-to-back access, ack in the last WAIT cycle, timeout into ERR, and
// asynchronous reset mid-WAIT. Expected outputs and the expected stall count
// are queued when stimulus is applied and compared when the DUT settles.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 4;

    // Expected output bundle:
    // {dmem_req, PCWrite, PCSrc, IFID_Write, IDEX_Write, EXMEM_Write,
    //  IFID_Flush, IDEX_Flush, EXMEM_Flush, MEMWB_Bubble, mem_err}
    localparam logic [10:0] O_RUN   = 11'b0_1_0_111_000_0_0;
    localparam logic [10:0] O_ZL    = 11'b1_1_0_111_000_0_0;
    localparam logic [10:0] O_STALL = 11'b1_0_0_000_000_1_0;
    localparam logic [10:0] O_BR    = 11'b0_1_1_111_111_0_0;
    localparam logic [10:0] O_LU    = 11'b0_0_0_011_010_0_0;
    localparam logic [10:0] O_ZL_LU = 11'b1_0_0_011_010_0_0;
    localparam logic [10:0] O_ERR   = 11'b0_0_0_000_000_1_1;

    logic        CLK = 1'b0;
    logic        RST;
    logic        MEM_MemRead, MEM_MemWrite, MEM_Branch, MEM_zero, EX_MemRead;
    logic [4:0]  EX_WriteReg, ID_Rs, ID_Rt;
    logic        dmem_ack;
    logic        dmem_req, PCWrite, PCSrc;
    logic        IFID_Write, IDEX_Write, EXMEM_Write;
    logic        IFID_Flush, IDEX_Flush, EXMEM_Flush;
    logic        MEMWB_Bubble, mem_err;
    logic [15:0] stall_cycles;
    logic [10:0] act_outs;

    pipeline_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .MEM_MemRead  (MEM_MemRead),
        .MEM_MemWrite (MEM_MemWrite),
        .MEM_Branch   (MEM_Branch),
        .MEM_zero     (MEM_zero),
        .EX_MemRead   (EX_MemRead),
        .EX_WriteReg  (EX_WriteReg),
        .ID_Rs        (ID_Rs),
        .ID_Rt        (ID_Rt),
        .dmem_ack     (dmem_ack),
        .dmem_req     (dmem_req),
        .PCWrite      (PCWrite),
        .PCSrc        (PCSrc),
        .IFID_Write   (IFID_Write),
        .IDEX_Write   (IDEX_Write),
        .EXMEM_Write  (EXMEM_Write),
        .IFID_Flush   (IFID_Flush),
        .IDEX_Flush   (IDEX_Flush),
        .EXMEM_Flush  (EXMEM_Flush),
        .MEMWB_Bubble (MEMWB_Bubble),
        .mem_err      (mem_err),
        .stall_cycles (stall_cycles)
    );

    assign act_outs = {dmem_req, PCWrite, PCSrc, IFID_Write, IDEX_Write,
                       EXMEM_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush,
                       MEMWB_Bubble, mem_err};

    always #5 CLK = ~CLK;

    // Scoreboard entry: what the DUT must show this cycle and after the edge.
    typedef struct {
        string       name;
        logic [10:0] outs;
        logic [15:0] cnt;
    } exp_t;

    // One combinational vector, applied for exactly one cycle in IDLE.
    typedef struct {
        string       name;
        logic        mr, mw, br, z, exmr;
        logic [4:0]  wr, rs, rt;
        logic        ack;
        logic [10:0] outs;
        logic        inc;
    } vec_t;

    exp_t        sb_q[$];
    vec_t        vecs[13];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] model_cnt;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic mr, input logic mw, input logic br,
                         input logic z, input logic exmr, input logic [4:0] wr,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic ack);
        MEM_MemRead  = mr;
        MEM_MemWrite = mw;
        MEM_Branch   = br;
        MEM_zero     = z;
        EX_MemRead   = exmr;
        EX_WriteReg  = wr;
        ID_Rs        = rs;
        ID_Rt        = rt;
        dmem_ack     = ack;
    endtask

    // Called at posedge+1 with inputs applied. Checks the outputs at the
    // negedge and stall_cycles just after the next rising edge.
    task automatic step(input string name, input logic [10:0] outs,
                        input logic inc);
        exp_t e;
        e.name = name;
        e.outs = outs;
        e.cnt  = (inc && model_cnt != 16'hFFFF) ? model_cnt + 16'd1 : model_cnt;
        sb_q.push_back(e);
        @(negedge CLK);
        e = sb_q.pop_front();
        check({e.name, " outs"}, 32'(act_outs), 32'(e.outs));
        @(posedge CLK);
        #1;
        check({e.name, " stall_cycles"}, 32'(stall_cycles), 32'(e.cnt));
        model_cnt = e.cnt;
    endtask

    function automatic vec_t mk(input string n, input logic mr, input logic mw,
                                input logic br, input logic z, input logic exmr,
                                input logic [4:0] wr, input logic [4:0] rs,
                                input logic [4:0] rt, input logic ack,
                                input logic [10:0] o, input logic inc);
        vec_t v;
        v.name = n; v.mr = mr; v.mw = mw; v.br = br; v.z = z; v.exmr = exmr;
        v.wr = wr; v.rs = rs; v.rt = rt; v.ack = ack; v.outs = o; v.inc = inc;
        return v;
    endfunction

    // Watchdog: the bench never needs anywhere near this long.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            name          mr mw br z exmr wr     rs     rt    ack outs     inc
        vecs[0]  = mk("idle",        0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  0, O_RUN,   0);
        vecs[1]  = mk("zl_load",     1, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  1, O_ZL,    0);
        vecs[2]  = mk("zl_store",    0, 1, 0, 0, 0, 5'd0,  5'd0,  5'd0,  1, O_ZL,    0);
        vecs[3]  = mk("br_taken",    0, 0, 1, 1, 0, 5'd0,  5'd0,  5'd0,  0, O_BR,    0);
        vecs[4]  = mk("br_not",      0, 0, 1, 0, 0, 5'd0,  5'd0,  5'd0,  0, O_RUN,   0);
        vecs[5]  = mk("lu_rt",       0, 0, 0, 0, 1, 5'd8,  5'd3,  5'd8,  0, O_LU,    1);
        vecs[6]  = mk("lu_rs",       0, 0, 0, 0, 1, 5'd5,  5'd5,  5'd9,  0, O_LU,    1);
        vecs[7]  = mk("lu_r0",       0, 0, 0, 0, 1, 5'd0,  5'd0,  5'd7,  0, O_RUN,   0);
        vecs[8]  = mk("no_load",     0, 0, 0, 0, 0, 5'd8,  5'd1,  5'd8,  0, O_RUN,   0);
        vecs[9]  = mk("br_plus_lu",  0, 0, 1, 1, 1, 5'd8,  5'd8,  5'd2,  0, O_BR,    0);
        vecs[10] = mk("lu_nomatch",  1'b0, 0, 0, 0, 1, 5'd8, 5'd9, 5'd10, 0, O_RUN, 0);
        vecs[11] = mk("stray_ack",   0, 0, 0, 0, 0, 5'd0,  5'd0,  5'd0,  1, O_RUN,   0);
        vecs[12] = mk("zl_plus_lu",  1, 0, 0, 0, 1, 5'd12, 5'd12, 5'd0,  1, O_ZL_LU, 1);

        // Reset state
        RST = 1'b1;
        drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        model_cnt = 16'd0;
        #12;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        check("reset outs", 32'(act_outs), 32'(O_RUN));
        check("reset stall_cycles", 32'(stall_cycles), 32'd0);

        // Table of single-cycle control vectors
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].mr, vecs[i].mw, vecs[i].br, vecs[i].z, vecs[i].exmr,
                  vecs[i].wr, vecs[i].rs, vecs[i].rt, vecs[i].ack);
            step(vecs[i].name, vecs[i].outs, vecs[i].inc);
        end

        // 3-cycle store: ack on the 4th cycle, released in the ack cycle
        drive(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        for (int i = 0; i < 3; i++) step("store3 wait", O_STALL, 1);
        dmem_ack = 1'b1;
        step("store3 ack", O_ZL, 0);
        // Back-to-back load starts a fresh request from IDLE
        drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step("b2b req", O_STALL, 1);
        dmem_ack = 1'b1;
        step("b2b ack", O_ZL, 0);
        drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step("b2b idle", O_RUN, 0);

        // Ack in the last WAIT cycle beats the timeout
        drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        for (int i = 0; i < TIMEOUT; i++) step("late_ok wait", O_STALL, 1);
        dmem_ack = 1'b1;
        step("late_ok ack", O_ZL, 0);
        drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step("late_ok idle", O_RUN, 0);

        // Timeout: 1 IDLE + TIMEOUT WAIT cycles, ERR from cycle TIMEOUT+2
        drive(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        for (int i = 0; i < TIMEOUT + 1; i++) step("tmo wait", O_STALL, 1);
        step("tmo err", O_ERR, 1);
        dmem_ack = 1'b1;
        step("tmo late_ack", O_ERR, 1);
        drive(0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0);
        step("tmo err_branch", O_ERR, 1);
        drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step("tmo err_idle", O_ERR, 1);
        RST = 1'b1;
        #1;
        check("tmo rst mem_err", 32'(mem_err), 32'd0);
        check("tmo rst outs", 32'(act_outs), 32'(O_RUN));
        model_cnt = 16'd0;
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Asynchronous reset mid-WAIT with no clock edge in between
        drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        step("rst_mid idle", O_STALL, 1);
        step("rst_mid wait", O_STALL, 1);
        drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        #1;
        check("rst_mid pre dmem_req", 32'(dmem_req), 32'd1);
        RST = 1'b1;
        #1;
        check("rst_mid dmem_req", 32'(dmem_req), 32'd0);
        check("rst_mid mem_err", 32'(mem_err), 32'd0);
        check("rst_mid stall_cycles", 32'(stall_cycles), 32'd0);
        check("rst_mid PCWrite", 32'(PCWrite), 32'd1);
        model_cnt = 16'd0;
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        step("post_rst idle", O_RUN, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
